// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and leading-zero helper for the display scan path
// Contents: digit count/widths, all-anodes-off pattern, lz_mask() leading-zero mask.
package disp_pkg;

  localparam int NUM_DIG = 8;
  localparam int SEL_W   = 3;
  localparam int NIB_W   = 4;

  localparam logic [NUM_DIG-1:0] ANODE_OFF = 8'hFF;

  // Bit i is set when digit i and every digit above it are zero.
  // Digit 0 is never flagged so an all-zero value still shows one "0".
  function automatic logic [NUM_DIG-1:0] lz_mask(input logic [NUM_DIG*NIB_W-1:0] val);
    logic above_zero;
    lz_mask    = '0;
    above_zero = 1'b1;
    for (int i = NUM_DIG - 1; i >= 1; i--) begin
      above_zero = above_zero & (val[i*NIB_W +: NIB_W] == '0);
      lz_mask[i] = above_zero;
    end
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - per-digit slot counter with blanking window
// Ports:
//   clock_i     system clock
//   reset_i     synchronous active-high reset
//   slot_end_o  high in the last cycle of a slot (cnt == TICK_DIV-1)
//   in_blank_o  next-cycle count falls inside the blanking window
module scan_tick_gen #(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 500
) (
  input  logic clock_i,
  input  logic reset_i,
  output logic slot_end_o,
  output logic in_blank_o
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign slot_end_o = (cnt_q == CNT_MAX);
  assign cnt_d      = slot_end_o ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Blanking is judged on the next count so the registered anode in the
  // parent lines up with the cycle that count is actually held.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign in_blank_o = 1'b0;
    end else begin : g_blank
      assign in_blank_o = (cnt_d < CNT_W'(BLANK_CYC));
    end
  endgenerate

endmodule

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 8-digit seven-segment scan scheduler with frame-aligned loads
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   val_in, load_req    32-bit value and its load request
//   load_ack            one-cycle pulse when a value becomes active
//   dig_en, lz_sup      per-digit enable mask, leading-zero suppression enable
//   sel, hex_out        digit index and its nibble
//   anode, blank        active-low one-hot anode drive, all-off flag
//   frame_done          one-cycle pulse with the 7->0 wrap of sel
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 500
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_DIG*NIB_W-1:0] val_in,
  input  logic                     load_req,
  output logic                     load_ack,
  input  logic [NUM_DIG-1:0]       dig_en,
  input  logic                     lz_sup,
  output logic [SEL_W-1:0]         sel,
  output logic [NIB_W-1:0]         hex_out,
  output logic [NUM_DIG-1:0]       anode,
  output logic                     blank,
  output logic                     frame_done
);

  logic slot_end, in_blank, boundary;

  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [NUM_DIG*NIB_W-1:0] active_q, active_d;
  logic [NUM_DIG*NIB_W-1:0] pending_q, pending_d;
  logic                     pend_vld_q, pend_vld_d;
  logic [NIB_W-1:0]         hex_q, hex_d;
  logic [NUM_DIG-1:0]       anode_q, anode_d;
  logic                     blank_q, blank_d;
  logic                     ack_q, ack_d;
  logic                     fd_q, fd_d;
  logic [NUM_DIG-1:0]       lz;
  logic                     dark;

  scan_tick_gen #(
    .TICK_DIV  (TICK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_tick (
    .clock_i    (clock),
    .reset_i    (reset),
    .slot_end_o (slot_end),
    .in_blank_o (in_blank)
  );

  assign boundary = slot_end && (sel_q == SEL_W'(NUM_DIG - 1));

  always_comb begin
    active_d   = active_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    fd_d       = boundary;
    sel_d      = slot_end ? sel_q + SEL_W'(1) : sel_q;

    // A request landing on the boundary itself wins over anything pending,
    // so the newest value is what the next frame shows.
    if (boundary) begin
      if (load_req) begin
        active_d   = val_in;
        pend_vld_d = 1'b0;
        ack_d      = 1'b1;
      end else if (pend_vld_q) begin
        active_d   = pending_q;
        pend_vld_d = 1'b0;
        ack_d      = 1'b1;
      end
    end else if (load_req) begin
      pending_d  = val_in;
      pend_vld_d = 1'b1;
    end

    // All outputs derive from next-state values so sel, hex_out and anode
    // change together on the same edge.
    lz      = lz_sup ? lz_mask(active_d) : '0;
    hex_d   = active_d[sel_d*NIB_W +: NIB_W];
    dark    = in_blank | ~dig_en[sel_d] | lz[sel_d];
    anode_d = dark ? ANODE_OFF : ~(NUM_DIG'(1) << sel_d);
    blank_d = (anode_d == ANODE_OFF);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q      <= '0;
      active_q   <= '0;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      hex_q      <= '0;
      anode_q    <= ANODE_OFF;
      blank_q    <= 1'b1;
      ack_q      <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      hex_q      <= hex_d;
      anode_q    <= anode_d;
      blank_q    <= blank_d;
      ack_q      <= ack_d;
      fd_q       <= fd_d;
    end
  end

  assign sel        = sel_q;
  assign hex_out    = hex_q;
  assign anode      = anode_q;
  assign blank      = blank_q;
  assign load_ack   = ack_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - self-checking bench for disp_scan_ctrl
module tb_disp_scan_ctrl;

  localparam int TD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = 8 * TD;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] val_in;
  logic        load_req;
  logic        load_ack;
  logic [7:0]  dig_en;
  logic        lz_sup;
  logic [2:0]  sel;
  logic [3:0]  hex_out;
  logic [7:0]  anode;
  logic        blank;
  logic        frame_done;

  disp_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
    .clock      (clock),
    .reset      (reset),
    .val_in     (val_in),
    .load_req   (load_req),
    .load_ack   (load_ack),
    .dig_en     (dig_en),
    .lz_sup     (lz_sup),
    .sel        (sel),
    .hex_out    (hex_out),
    .anode      (anode),
    .blank      (blank),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int ack_cnt  = 0;
  bit seen_two = 0;

  // Reference model: time since reset drives the scan position directly.
  int          m_t;
  logic [31:0] m_act, m_pend;
  bit          m_pv;
  logic [2:0]  e_sel;
  logic [3:0]  e_hex;
  logic [7:0]  e_anode;
  logic        e_blank, e_ack, e_fd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_lz(input logic [31:0] v, input int i);
    return (i > 0) && ((v >> (4 * i)) == 0);
  endfunction

  task automatic model_step();
    bit bnd;
    int s, c;
    logic [7:0] one;
    if (reset) begin
      m_t = 0; m_act = 0; m_pend = 0; m_pv = 0;
      e_sel = 0; e_hex = 0; e_anode = 8'hFF; e_blank = 1; e_ack = 0; e_fd = 0;
      return;
    end
    bnd   = (m_t % FRAME) == FRAME - 1;
    e_ack = 0;
    if (bnd) begin
      if (load_req) begin m_act = val_in; m_pv = 0; e_ack = 1; end
      else if (m_pv) begin m_act = m_pend; m_pv = 0; e_ack = 1; end
    end else if (load_req) begin
      m_pend = val_in; m_pv = 1;
    end
    m_t++;
    s     = (m_t / TD) % 8;
    c     = m_t % TD;
    e_fd  = bnd;
    e_sel = 3'(s);
    e_hex = 4'((m_act >> (4 * s)) & 32'hF);
    one   = 8'h01;
    if (c < BC || !dig_en[s] || (lz_sup && is_lz(m_act, s))) e_anode = 8'hFF;
    else e_anode = ~(one << s);
    e_blank = (e_anode == 8'hFF);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    @(negedge clock);
    chk("sel", 32'(sel), 32'(e_sel));
    chk("hex_out", 32'(hex_out), 32'(e_hex));
    chk("anode", 32'(anode), 32'(e_anode));
    chk("blank", 32'(blank), 32'(e_blank));
    chk("load_ack", 32'(load_ack), 32'(e_ack));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    if (load_ack === 1'b1) ack_cnt++;
    if (hex_out === 4'h2) seen_two = 1;
  endtask

  task automatic run_until_phase(input int p);
    for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != p; k++) cycle();
    checks++;
    if ((m_t % FRAME) != p) begin
      failures++;
      $display("FAIL phase_wait actual=%0d required=%0d", m_t % FRAME, p);
    end
  endtask

  task automatic wait_ack();
    int k;
    k = 0;
    while (load_ack !== 1'b1 && k < FRAME + 4) begin
      cycle();
      k++;
    end
    chk("ack_wait", 32'(load_ack), 32'd1);
  endtask

  typedef struct {
    logic [31:0] val;
    logic        lz;
    logic [7:0]  en;
    logic [7:0]  lit;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, f0, fd_seen;
    logic [7:0] one, ex_an;

    vecs[0] = '{val: 32'h8765_4321, lz: 1'b1, en: 8'hFF, lit: 8'hFF};
    vecs[1] = '{val: 32'h0000_0A05, lz: 1'b1, en: 8'hFF, lit: 8'h07};
    vecs[2] = '{val: 32'h0000_0000, lz: 1'b1, en: 8'hFF, lit: 8'h01};
    vecs[3] = '{val: 32'h0000_0000, lz: 1'b0, en: 8'hFF, lit: 8'hFF};
    vecs[4] = '{val: 32'h8765_4321, lz: 1'b1, en: 8'hF5, lit: 8'hF5};
    vecs[5] = '{val: 32'h0000_0000, lz: 1'b1, en: 8'hFE, lit: 8'h00};

    reset = 1; val_in = 0; load_req = 0; dig_en = 8'hFF; lz_sup = 0;
    @(negedge clock);
    cycle();
    cycle();
    reset = 0;

    // Free-running scan with no loads: one frame_done per frame.
    fd_seen = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      cycle();
      if (frame_done === 1'b1) fd_seen++;
    end
    chk("frame_done_count", 32'(fd_seen), 32'd2);

    // Table: load each value, then inspect every slot just past blanking.
    one = 8'h01;
    for (int r = 0; r < 6; r++) begin
      dig_en = vecs[r].en; lz_sup = vecs[r].lz;
      run_until_phase(9);
      val_in = vecs[r].val; load_req = 1;
      cycle();
      load_req = 0;
      wait_ack();
      chk("ack_sel0", 32'(sel), 32'd0);
      for (int s = 0; s < 8; s++) begin
        cycle();
        ex_an = vecs[r].lit[s] ? ~(one << s) : 8'hFF;
        chk("row_sel", 32'(sel), 32'(s));
        chk("row_anode", 32'(anode), 32'(ex_an));
        chk("row_hex", 32'(hex_out), (vecs[r].val >> (4 * s)) & 32'hF);
        chk("row_blank", 32'(blank), 32'(ex_an == 8'hFF));
        for (int k = 0; k < TD - 1; k++) cycle();
      end
    end

    // Two mid-frame requests, then one on the boundary cycle itself.
    dig_en = 8'hFF; lz_sup = 0;
    run_until_phase(8);
    a0 = ack_cnt; seen_two = 0;
    val_in = 32'h1111_1111; load_req = 1; cycle(); load_req = 0;
    cycle(); cycle();
    val_in = 32'h2222_2222; load_req = 1; cycle(); load_req = 0;
    run_until_phase(FRAME - 1);
    val_in = 32'h3333_3333; load_req = 1; cycle(); load_req = 0;
    chk("bnd_ack", 32'(load_ack), 32'd1);
    chk("bnd_hex", 32'(hex_out), 32'h3);
    for (int k = 0; k < 2 * FRAME; k++) cycle();
    chk("bnd_ack_count", 32'(ack_cnt - a0), 32'd1);
    chk("never_two", 32'(seen_two), 32'd0);

    // Reset in slot 5 with a load pending: dropped with no ack.
    run_until_phase(5 * TD + 2);
    val_in = 32'hDEAD_BEEF; load_req = 1; cycle(); load_req = 0;
    cycle();
    reset = 1; cycle(); reset = 0;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_anode", 32'(anode), 32'hFF);
    f0 = ack_cnt;
    for (int k = 0; k < 3 * FRAME; k++) cycle();
    chk("rst_no_ack", 32'(ack_cnt - f0), 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      reset    = ($urandom_range(0, 299) == 0);
      load_req = ($urandom_range(0, 19) == 0);
      val_in   = $urandom >> (4 * $urandom_range(0, 8));
      if ($urandom_range(0, 15) == 0) dig_en = 8'($urandom);
      if ($urandom_range(0, 15) == 0) lz_sup = 1'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
